matrix_scan_scheduler: RTL and testbench

MATRIX_SCAN_SCHEDULER -- requirements
Module: matrix_scan_scheduler

---
 rtl/matrix_scan_scheduler.sv | 139 +++++++++++++
 tb/tb_matrix_scan_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_scheduler.sv
// Row / bit-plane scan sequencer for a multiplexed LED matrix: requests a row shift,
// blanks the panel, latches the row, then lights it for a binary-weighted dwell.
module matrix_scan_scheduler #(
   parameter int PIXEL_HALFHEIGHT  = 16,
   parameter int BRIGHTNESS_LEVELS = 6,
   parameter int BASE_ON_CYCLES    = 8,
   parameter int BLANK_CYCLES      = 2,
   localparam int ROW_W   = (PIXEL_HALFHEIGHT  > 1) ? $clog2(PIXEL_HALFHEIGHT)  : 1,
   localparam int PLANE_W = (BRIGHTNESS_LEVELS > 1) ? $clog2(BRIGHTNESS_LEVELS) : 1
) (
   input  logic               clk_root,
   input  logic               reset_n,
   input  logic               enable,
   input  logic               shift_done,
   output logic               shift_start,
   output logic [ROW_W-1:0]   load_row,
   output logic [PLANE_W-1:0] load_plane,
   output logic [ROW_W-1:0]   panel_addr,
   output logic               latch,
   output logic               oe_n,
   output logic               frame_start
);

   // The counter only ever holds a dwell or blank length minus one.
   localparam int DWELL_MAX = BASE_ON_CYCLES << (BRIGHTNESS_LEVELS - 1);
   localparam int CNT_MAX   = (DWELL_MAX > BLANK_CYCLES) ? DWELL_MAX : BLANK_CYCLES;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SHIFT   = 3'd1;
   localparam logic [2:0] S_BLANK   = 3'd2;
   localparam logic [2:0] S_LATCH   = 3'd3;
   localparam logic [2:0] S_DISPLAY = 3'd4;

   logic [2:0]         r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [ROW_W-1:0]   r_load_row;
   logic [PLANE_W-1:0] r_load_plane;
   logic [ROW_W-1:0]   r_panel_addr;
   logic               r_latch;
   logic               r_oe_n;
   logic               r_shift_start;
   logic               r_frame_start;

   logic [CNT_W-1:0]   w_dwell;
   logic               w_plane_wrap;
   logic [PLANE_W-1:0] w_next_plane;
   logic [ROW_W-1:0]   w_next_row;

   assign w_dwell = CNT_W'(BASE_ON_CYCLES) << r_load_plane;

   // NOTE: every signal driven here gets a value before any branch, so no latch is inferred.
   always_comb begin
      w_plane_wrap = (r_load_plane == PLANE_W'(BRIGHTNESS_LEVELS - 1));
      w_next_plane = w_plane_wrap ? '0 : r_load_plane + PLANE_W'(1);
      w_next_row   = r_load_row;
      if (w_plane_wrap) begin
         w_next_row = (r_load_row == ROW_W'(PIXEL_HALFHEIGHT - 1)) ? '0 : r_load_row + ROW_W'(1);
      end
   end

   // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk_root) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_load_row    <= '0;
         r_load_plane  <= '0;
         r_panel_addr  <= '0;
         r_latch       <= 1'b0;
         r_oe_n        <= 1'b1;
         r_shift_start <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_shift_start <= 1'b0;
         r_frame_start <= 1'b0;
         r_latch       <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (enable) begin
                  r_state       <= S_SHIFT;
                  r_shift_start <= 1'b1;
                  r_frame_start <= (r_load_row == '0) && (r_load_plane == '0);
               end
            end
            S_SHIFT: begin
               // A done pulse coincident with our own request belongs to an older shift.
               if (shift_done && !r_shift_start) begin
                  r_state <= S_BLANK;
                  r_cnt   <= CNT_W'(BLANK_CYCLES - 1);
               end
            end
            S_BLANK: begin
               if (r_cnt == '0) begin
                  r_state      <= S_LATCH;
                  r_latch      <= 1'b1;
                  r_panel_addr <= r_load_row;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            S_LATCH: begin
               r_state <= S_DISPLAY;
               r_oe_n  <= 1'b0;
               r_cnt   <= w_dwell - CNT_W'(1);
            end
            S_DISPLAY: begin
               if (r_cnt == '0) begin
                  r_oe_n       <= 1'b1;
                  r_load_row   <= w_next_row;
                  r_load_plane <= w_next_plane;
                  if (enable) begin
                     r_state       <= S_SHIFT;
                     r_shift_start <= 1'b1;
                     r_frame_start <= (w_next_row == '0) && (w_next_plane == '0);
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_oe_n  <= 1'b1;
            end
         endcase
      end
   end

   assign shift_start = r_shift_start;
   assign frame_start = r_frame_start;
   assign load_row    = r_load_row;
   assign load_plane  = r_load_plane;
   assign panel_addr  = r_panel_addr;
   assign latch       = r_latch;
   assign oe_n        = r_oe_n;

endmodule

// File: tb/tb_matrix_scan_scheduler.sv
// Scoreboard bench for matrix_scan_scheduler: stimulus queues expected shift/latch/dwell
// events, a negedge monitor turns DUT activity into events and compares them in order.
module tb_matrix_scan_scheduler;

   localparam int LATCH_GAP = 8;  // shift_start -> latch: 5 shift cycles + 2 blank + 1

   typedef enum int {EV_SHIFT, EV_LATCH, EV_DISP} ev_kind_t;
   typedef struct {
      ev_kind_t kind;
      int       a;
      int       b;
      int       c;
   } ev_t;
   typedef struct {
      int row;
      int plane;
      int frame;
      int len;
   } sf_t;

   logic       clk_root = 1'b0;
   logic       reset_n;
   logic       enable;
   logic       shift_done;
   logic       shift_start;
   logic [1:0] load_row;
   logic [0:0] load_plane;
   logic [1:0] panel_addr;
   logic       latch;
   logic       oe_n;
   logic       frame_start;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   t_shift  = 0;
   int   run_len  = 0;
   int   n_shift_seen = 0;
   ev_t  exp_q[$];
   sf_t  sf_tab [0:11];

   matrix_scan_scheduler #(
      .PIXEL_HALFHEIGHT (4),
      .BRIGHTNESS_LEVELS(2),
      .BASE_ON_CYCLES   (4),
      .BLANK_CYCLES     (2)
   ) dut (
      .clk_root   (clk_root),
      .reset_n    (reset_n),
      .enable     (enable),
      .shift_done (shift_done),
      .shift_start(shift_start),
      .load_row   (load_row),
      .load_plane (load_plane),
      .panel_addr (panel_addr),
      .latch      (latch),
      .oe_n       (oe_n),
      .frame_start(frame_start)
   );

   always #5 clk_root = ~clk_root;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic observe(input ev_t got);
      ev_t exp;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL unexpected_event: kind %0d a=%0d b=%0d c=%0d, expected no event (t=%0t)",
                  int'(got.kind), got.a, got.b, got.c, $time);
      end else begin
         exp = exp_q.pop_front();
         check("event_kind", int'(got.kind), int'(exp.kind));
         case (exp.kind)
            EV_SHIFT: begin
               check("shift_load_row",    got.a, exp.a);
               check("shift_load_plane",  got.b, exp.b);
               check("shift_frame_start", got.c, exp.c);
            end
            EV_LATCH: begin
               check("latch_panel_addr", got.a, exp.a);
               check("latch_gap",        got.c, exp.c);
            end
            default: check("dwell_cycles", got.a, exp.a);
         endcase
      end
   endtask

   // Monitor: dwell end is reported before a coincident shift_start to keep queue order.
   always @(negedge clk_root) begin
      ev_t ev;
      cyc++;
      if (!reset_n) begin
         run_len = 0;
      end else begin
         if (!oe_n) begin
            run_len++;
         end else if (run_len > 0) begin
            ev = '{kind: EV_DISP, a: run_len, b: 0, c: 0};
            observe(ev);
            run_len = 0;
         end
         if (shift_start) begin
            n_shift_seen++;
            t_shift = cyc;
            check("shift_oe_dark", int'(oe_n), 1);
            check("shift_no_latch", int'(latch), 0);
            ev = '{kind: EV_SHIFT, a: int'(load_row), b: int'(load_plane), c: int'(frame_start)};
            observe(ev);
         end
         if (latch) begin
            check("latch_oe_dark", int'(oe_n), 1);
            ev = '{kind: EV_LATCH, a: int'(panel_addr), b: 0, c: cyc - t_shift};
            observe(ev);
         end
      end
   end

   task automatic push_sf(input int i, input bit with_disp);
      exp_q.push_back('{kind: EV_SHIFT, a: sf_tab[i].row, b: sf_tab[i].plane, c: sf_tab[i].frame});
      exp_q.push_back('{kind: EV_LATCH, a: sf_tab[i].row, b: 0, c: LATCH_GAP});
      if (with_disp) exp_q.push_back('{kind: EV_DISP, a: sf_tab[i].len, b: 0, c: 0});
   endtask

   // Wait for shift_start, then answer with shift_done five cycles later.
   task automatic handshake(input bit early_done);
      bit found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         @(posedge clk_root); #1;
         found = shift_start;
      end
      check("shift_start_seen", int'(found), 1);
      if (early_done) shift_done = 1'b1;
      @(posedge clk_root); #1;
      shift_done = 1'b0;
      repeat (4) @(posedge clk_root);
      #1 shift_done = 1'b1;
      @(posedge clk_root); #1;
      shift_done = 1'b0;
   endtask

   task automatic wait_oe(input bit level);
      bit found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         @(posedge clk_root); #1;
         found = (oe_n == level);
      end
      check("oe_n_level_reached", int'(found), 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_shift_start"}, int'(shift_start), 0);
      check({tag, "_frame_start"}, int'(frame_start), 0);
      check({tag, "_latch"},       int'(latch),       0);
      check({tag, "_oe_n"},        int'(oe_n),        1);
      check({tag, "_load_row"},    int'(load_row),    0);
      check({tag, "_load_plane"},  int'(load_plane),  0);
      check({tag, "_panel_addr"},  int'(panel_addr),  0);
   endtask

   initial begin
      int snap;
      // row, plane, frame_start, dwell cycles (4 << plane)
      sf_tab = '{'{0, 0, 1, 4}, '{0, 1, 0, 8}, '{1, 0, 0, 4}, '{1, 1, 0, 8},
                 '{2, 0, 0, 4}, '{2, 1, 0, 8}, '{3, 0, 0, 4}, '{3, 1, 0, 8},
                 '{0, 0, 1, 4}, '{0, 1, 0, 8}, '{1, 0, 0, 4}, '{0, 0, 1, 4}};
      reset_n    = 1'b0;
      enable     = 1'b0;
      shift_done = 1'b0;
      repeat (3) @(posedge clk_root);
      #1 check_reset_outputs("por");

      // Full frame plus wrap; sub-frame 2 also gets a done pulse in its request cycle.
      push_sf(0, 1'b1);
      enable  = 1'b1;
      reset_n = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (i > 0) push_sf(i, 1'b1);
         handshake(i == 2);
      end

      // Enable dropped mid-dwell: the dwell finishes, then the scan parks in IDLE.
      push_sf(9, 1'b1);
      handshake(1'b0);
      wait_oe(1'b0);
      enable = 1'b0;
      wait_oe(1'b1);
      snap = n_shift_seen;
      repeat (10) @(posedge clk_root);
      #1;
      check("idle_no_shift_start", n_shift_seen, snap);
      check("idle_oe_n", int'(oe_n), 1);
      check("idle_load_row", int'(load_row), 1);
      check("idle_load_plane", int'(load_plane), 0);

      // Resume at row 1 plane 0, then reset in the middle of its dwell.
      push_sf(10, 1'b0);
      enable = 1'b1;
      handshake(1'b0);
      wait_oe(1'b0);
      repeat (2) @(posedge clk_root);
      #1 reset_n = 1'b0;
      @(posedge clk_root); #1;
      check_reset_outputs("mid_display_reset");
      enable = 1'b0;
      @(posedge clk_root); #1;
      reset_n = 1'b1;
      snap = n_shift_seen;
      @(posedge clk_root); #1;
      shift_done = 1'b1;
      @(posedge clk_root); #1;
      shift_done = 1'b0;
      repeat (6) @(posedge clk_root);
      #1;
      check_reset_outputs("idle_shift_done");
      check("idle_done_no_shift", n_shift_seen, snap);

      // Restart from the reset position: new frame at row 0 plane 0.
      push_sf(11, 1'b1);
      enable = 1'b1;
      handshake(1'b0);
      wait_oe(1'b0);
      enable = 1'b0;
      wait_oe(1'b1);
      repeat (4) @(posedge clk_root);
      #1;
      check("pending_events", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
